// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, branch redirect flush and data-memory freeze
// with bounded wait, plus saturating stall/flush event counters and a sticky timeout flag.
module hazard_control_unit #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_write_en,
  output logic             id_ex_flush,
  output logic             ex_mem_write_en,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout_err
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic load_use;
  logic timeout_hit;
  logic mem_busy;

  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == if_id_rs1) || (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));
  assign timeout_hit = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_END);
  assign mem_busy    = dmem_req && !dmem_ready && !timeout_hit;

  // Next state, counters and combinational pipeline controls
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    stall_cnt_d     = stall_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    timeout_err_d   = timeout_err_q;
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_write_en  = 1'b1;
    id_ex_flush     = 1'b0;
    ex_mem_write_en = 1'b1;
    mem_wb_bubble   = 1'b0;

    if (mem_busy) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_bubble   = 1'b1;
      state_d         = MEM_WAIT;
      wait_cnt_d      = (state_q == MEM_WAIT) ? wait_cnt_q + WAIT_W'(1) : '0;
    end else begin
      state_d    = RUN;
      wait_cnt_d = '0;
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (load_use) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_flush    = 1'b1;
      end
    end

    // Forced release: the wait ran out while memory still had not answered
    if (timeout_hit && !dmem_ready) timeout_err_d = 1'b1;

    if (!pc_write_en && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    if (reset) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_write_en  = 1'b0;
      id_ex_flush     = 1'b1;
      ex_mem_write_en = 1'b0;
      mem_wb_bubble   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign stall_cnt       = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;
  assign mem_timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (CNT_W=2, MEM_TIMEOUT=4); a queue-based
// scoreboard holds the expected per-cycle controls and counters.
module tb_hazard_control_unit;

  localparam logic [6:0] C_NORM = 7'b1101010;
  localparam logic [6:0] C_FRZ  = 7'b0000001;
  localparam logic [6:0] C_RDR  = 7'b1111110;
  localparam logic [6:0] C_LU   = 7'b0001110;
  localparam logic [6:0] C_RST  = 7'b0010101;

  typedef struct {
    string      name;
    logic [6:0] ctrl;
    logic       chk;
    logic [1:0] stall;
    logic [1:0] flush;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic       if_id_uses_rs2, id_ex_mem_read, ex_branch_taken, dmem_req, dmem_ready;
  logic       pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_flush;
  logic       ex_mem_write_en, mem_wb_bubble, mem_timeout_err;
  logic [1:0] stall_cnt, flush_cnt;

  exp_t sb_q[$];
  exp_t mon_e;
  logic [6:0] act_ctrl;
  logic stim_done = 1'b0;
  int   tests = 0;
  int   fails = 0;

  hazard_control_unit #(.CNT_W(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
    .id_ex_write_en(id_ex_write_en), .id_ex_flush(id_ex_flush),
    .ex_mem_write_en(ex_mem_write_en), .mem_wb_bubble(mem_wb_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout_err(mem_timeout_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the response expected in that cycle
  task automatic step(input string nm, input logic rst,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                      input logic [4:0] rd, input logic mrd, input logic br,
                      input logic req, input logic rdy,
                      input logic [6:0] ctrl, input logic chk,
                      input logic [1:0] s, input logic [1:0] f, input logic e);
    exp_t x;
    @(posedge clk);
    #1;
    reset = rst; if_id_rs1 = rs1; if_id_rs2 = rs2; if_id_uses_rs2 = uses;
    id_ex_rd = rd; id_ex_mem_read = mrd; ex_branch_taken = br;
    dmem_req = req; dmem_ready = rdy;
    x.name = nm; x.ctrl = ctrl; x.chk = chk; x.stall = s; x.flush = f; x.err = e;
    sb_q.push_back(x);
  endtask

  initial begin
    reset = 1'b1; if_id_rs1 = '0; if_id_rs2 = '0; if_id_uses_rs2 = 1'b0; id_ex_rd = '0;
    id_ex_mem_read = 1'b0; ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    //   name          rst rs1 rs2 use rd  mrd br req rdy ctrl   chk s  f  e
    step("reset",      1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,  1, 0, 0, 0);
    step("idle0",      0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1, 0, 0, 0);
    step("loaduse",    0, 5, 0, 0, 5, 1, 0, 0, 0, C_LU,   1, 0, 0, 0);
    step("after_lu",   0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1, 1, 0, 0);
    step("rd0",        0, 0, 0, 0, 0, 1, 0, 0, 0, C_NORM, 1, 1, 0, 0);
    step("rs2_unused", 0, 3, 7, 0, 7, 1, 0, 0, 0, C_NORM, 1, 1, 0, 0);
    step("rs2_used",   0, 3, 7, 1, 7, 1, 0, 0, 0, C_LU,   1, 1, 0, 0);
    step("after_lu2",  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1, 2, 0, 0);
    step("rst_a",      1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,  0, 0, 0, 0);
    step("rst_b",      1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,  1, 0, 0, 0);
    step("rdr_lu",     0, 5, 0, 0, 5, 1, 1, 0, 0, C_RDR,  1, 0, 0, 0);
    step("after_rdr",  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1, 0, 1, 0);
    step("frz1",       0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  1, 0, 1, 0);
    step("frz2",       0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  1, 1, 1, 0);
    step("frz3",       0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  1, 2, 1, 0);
    step("release",    0, 0, 0, 0, 0, 0, 0, 1, 1, C_NORM, 1, 3, 1, 0);
    step("run_again",  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1, 3, 1, 0);
    step("rst_c",      1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,  0, 0, 0, 0);
    step("rst_d",      1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,  1, 0, 0, 0);
    step("frz_br1",    0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ,  1, 0, 0, 0);
    step("frz_br2",    0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ,  1, 1, 0, 0);
    step("rel_br",     0, 0, 0, 0, 0, 0, 1, 1, 1, C_RDR,  1, 2, 0, 0);
    step("after_relbr",0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1, 2, 1, 0);
    step("to1",        0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  1, 2, 1, 0);
    step("to2",        0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  1, 3, 1, 0);
    step("to3",        0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  1, 3, 1, 0);
    step("to4",        0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  1, 3, 1, 0);
    step("to_release", 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NORM, 1, 3, 1, 0);
    step("err_set",    0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1, 3, 1, 1);
    step("frz_err",    0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  1, 3, 1, 1);
    step("rel_err",    0, 0, 0, 0, 0, 0, 0, 1, 1, C_NORM, 1, 3, 1, 1);
    step("err_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1, 3, 1, 1);
    step("rst_e",      1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,  0, 0, 0, 0);
    step("rst_f",      1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,  1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step($sformatf("rdr%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RDR, 1, 0,
           (i > 3) ? 2'd3 : 2'(i), 0);
    step("flush_sat",  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1, 0, 3, 0);
    step("mw1",        0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  1, 0, 3, 0);
    step("mw2",        0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  1, 1, 3, 0);
    step("rst_in_mw",  1, 0, 0, 0, 0, 0, 0, 1, 0, C_RST,  0, 0, 0, 0);
    step("post_rst",   0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1, 0, 0, 0);
    step("post_rst2",  0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1, 0, 0, 0);
    stim_done = 1'b1;
  end

  // Monitor: the controls are valid every cycle, so one queue entry is consumed per cycle
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      act_ctrl = {pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
                  id_ex_flush, ex_mem_write_en, mem_wb_bubble};
      tests = tests + 1;
      if (act_ctrl !== mon_e.ctrl) begin
        fails = fails + 1;
        $display("FAIL %s ctrl: got %b expected %b", mon_e.name, act_ctrl, mon_e.ctrl);
      end
      if (mon_e.chk) begin
        tests = tests + 1;
        if ({stall_cnt, flush_cnt, mem_timeout_err} !== {mon_e.stall, mon_e.flush, mon_e.err}) begin
          fails = fails + 1;
          $display("FAIL %s counters: got stall=%0d flush=%0d err=%b expected stall=%0d flush=%0d err=%b",
                   mon_e.name, stall_cnt, flush_cnt, mem_timeout_err,
                   mon_e.stall, mon_e.flush, mon_e.err);
        end
      end
    end else if (stim_done) begin
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of stall/flush event counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 64, max consecutive data-memory wait cycles before forced release (>=2).
REQ-003 SHALL have ports (one per line; clock and reset first; one clock, reset synchronous active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- if_id_rs1  in  5  rs1 of instruction in ID
- if_id_rs2  in  5  rs2 of instruction in ID
- if_id_uses_rs2  in  1  ID instruction reads rs2
- id_ex_rd  in  5  rd of instruction in EX
- id_ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump (PC redirect)
- dmem_req  in  1  MEM stage issues a data-memory access this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write_en  out  1  PC update enable
- if_id_write_en  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID clears to NOP
- id_ex_write_en  out  1  ID/EX register load enable
- id_ex_flush  out  1  ID/EX clears to bubble
- ex_mem_write_en  out  1  EX/MEM register load enable
- mem_wb_bubble  out  1  MEM/WB loads a bubble
- stall_cnt  out  CNT_W  cycles with pc_write_en=0 (excluding reset)
- flush_cnt  out  CNT_W  redirect events
- mem_timeout_err  out  1  sticky data-memory timeout flag

Function
REQ-004 SHALL implement FSM states RUN and MEM_WAIT; control outputs SHALL be combinational from state and inputs; stall_cnt, flush_cnt, mem_timeout_err, state, wait counter SHALL be registered.
REQ-005 SHALL define load_use = id_ex_mem_read & (id_ex_rd!=0) & ((id_ex_rd==if_id_rs1) | (if_id_uses_rs2 & id_ex_rd==if_id_rs2)).
REQ-006 SHALL define mem_busy = dmem_req & ~dmem_ready & ~timeout_hit, where timeout_hit = (state==MEM_WAIT) & (wait_cnt==MEM_TIMEOUT-1).
REQ-007 Priority SHALL be mem_busy > ex_branch_taken > load_use > normal.
REQ-008 Normal: all write enables 1, flushes 0, mem_wb_bubble 0.
REQ-009 mem_busy (freeze): pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en = 0; mem_wb_bubble=1; flushes 0; next state MEM_WAIT.
REQ-010 ex_branch_taken (no mem_busy): all write enables 1; if_id_flush=1, id_ex_flush=1; flush_cnt increments; load_use ignored.
REQ-011 load_use (no mem_busy, no redirect): pc_write_en=0, if_id_write_en=0, id_ex_flush=1, other enables 1; exactly one bubble per hazard (hazard clears once bubble reaches EX).
REQ-012 MEM_WAIT: wait_cnt increments each cycle of mem_busy; cleared on entry from RUN and on exit.
REQ-013 MEM_WAIT with dmem_ready=1: release in same cycle per REQ-007..011 (normal/redirect/load_use evaluated), next state RUN.
REQ-014 timeout_hit with dmem_ready=0: set mem_timeout_err (sticky until reset), release as if ready, next state RUN.
REQ-015 ex_branch_taken held during freeze SHALL be applied on the release cycle only (one flush_cnt increment per release).
REQ-016 stall_cnt and flush_cnt SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-017 id_ex_rd==0 SHALL never cause a load-use stall.

Reset
REQ-018 While reset=1: state RUN, wait_cnt 0, stall_cnt 0, flush_cnt 0, mem_timeout_err 0; all write enables 0, if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1; counters do not count.
REQ-019 Reset asserted during MEM_WAIT SHALL abort the wait; first cycle after reset deassert is RUN with normal outputs if inputs idle.

Verification
REQ-020 Load-use: id_ex_mem_read=1, id_ex_rd=5, if_id_rs1=5 one cycle -> pc_write_en=0, if_id_write_en=0, id_ex_flush=1; stall_cnt=1 next cycle.
REQ-021 False hazard: id_ex_rd=0 matching rs1, and id_ex_rd=7=rs2 with if_id_uses_rs2=0 -> no stall, stall_cnt unchanged.
REQ-022 Redirect + load-use same cycle -> if_id_flush=1, id_ex_flush=1, pc_write_en=1; flush_cnt=1, stall_cnt=0.
REQ-023 dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 frozen cycles (all enables 0, mem_wb_bubble=1), release on 4th, stall_cnt=3, state RUN.
REQ-024 MEM_TIMEOUT=4, dmem_ready stuck 0 -> freeze 4 cycles, forced release, mem_timeout_err=1 sticky until reset.
REQ-025 CNT_W=2, 5 redirects -> flush_cnt=3 (saturated); reset mid-MEM_WAIT -> all counters 0, state RUN.
